// File: rtl/anton_neopixel_apb_loader.sv
// anton_neopixel_apb_loader: streaming APB master that feeds the neopixel APB
// slave. Buffers {last, byte} entries in a small FIFO and writes each byte to
// the raw pixel buffer at an auto-incrementing index. After the last byte of a
// frame it raises syncStart for SYNC_HOLD cycles.
module anton_neopixel_apb_loader #(
  parameter logic [15:0] BUFFER_END = 16'd767,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  REGION     = 2'b00,
  parameter int unsigned SYNC_HOLD  = 4
) (
  input  logic        apbPclk,
  input  logic        apbPresern,
  input  logic        pixValid,
  input  logic [7:0]  pixData,
  input  logic        pixLast,
  output logic        pixReady,
  output logic        apbPselx,
  output logic        apbPenable,
  output logic        apbPwrite,
  output logic [19:0] apbPaddr,
  output logic [7:0]  apbPwData,
  input  logic        apbPready,
  input  logic        apbPslverr,
  output logic        syncStart,
  output logic        frameDone,
  output logic        slvErr,
  output logic        busy
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_L     = (AW+1)'(1);
  localparam logic [7:0]  HOLD_LAST = 8'(SYNC_HOLD - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, SYNC} state_t;

  state_t      state;
  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;
  logic [AW:0] count;
  logic [AW-1:0] rdNext;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        headLast;
  logic [7:0]  headData;
  logic [7:0]  nextData;
  logic        moreAfterPop;
  logic [15:0] index;
  logic [15:0] indexInc;
  logic [7:0]  holdCnt;

  assign count    = wrPtr - rdPtr;
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_L);
  assign pixReady = apbPresern && !full;
  assign push     = pixValid && pixReady;
  assign pop      = (state == ACCESS) && apbPready;
  assign {headLast, headData} = mem[rdPtr[AW-1:0]];
  assign rdNext   = rdPtr[AW-1:0] + AW'(1);
  // Entry following the head after a pop; when the FIFO holds a single entry
  // it can only be the byte being pushed on this same edge.
  assign nextData     = (count > ONE_L) ? mem[rdNext][7:0] : pixData;
  assign moreAfterPop = (count > ONE_L) || push;
  assign indexInc     = (index == BUFFER_END) ? '0 : index + 16'd1;
  assign busy         = (state != IDLE) || !empty;

  // FIFO storage; pushes are blocked while in reset via pixReady.
  always_ff @(posedge apbPclk) begin
    if (push) mem[wrPtr[AW-1:0]] <= {pixLast, pixData};
  end

  // FIFO pointers.
  always_ff @(posedge apbPclk) begin
    if (!apbPresern) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + ONE_L;
      if (pop)  rdPtr <= rdPtr + ONE_L;
    end
  end

  // APB master FSM with registered bus outputs, index and sync pulse.
  always_ff @(posedge apbPclk) begin
    if (!apbPresern) begin
      state      <= IDLE;
      apbPselx   <= 1'b0;
      apbPenable <= 1'b0;
      apbPwrite  <= 1'b0;
      apbPaddr   <= '0;
      apbPwData  <= '0;
      syncStart  <= 1'b0;
      frameDone  <= 1'b0;
      slvErr     <= 1'b0;
      index      <= '0;
      holdCnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state      <= SETUP;
            apbPselx   <= 1'b1;
            apbPenable <= 1'b0;
            apbPwrite  <= 1'b1;
            apbPaddr   <= {REGION, index, 2'b00};
            apbPwData  <= headData;
          end
        end
        SETUP: begin
          state      <= ACCESS;
          apbPenable <= 1'b1;
        end
        ACCESS: begin
          if (apbPready) begin
            if (apbPslverr) slvErr <= 1'b1;
            if (headLast) begin
              index      <= '0;
              state      <= SYNC;
              apbPselx   <= 1'b0;
              apbPenable <= 1'b0;
              apbPwrite  <= 1'b0;
              syncStart  <= 1'b1;
              frameDone  <= (HOLD_LAST == 8'd0);
              holdCnt    <= '0;
            end else begin
              index <= indexInc;
              // Back-to-back: go straight to SETUP for the next entry.
              if (moreAfterPop) begin
                state      <= SETUP;
                apbPenable <= 1'b0;
                apbPaddr   <= {REGION, indexInc, 2'b00};
                apbPwData  <= nextData;
              end else begin
                state      <= IDLE;
                apbPselx   <= 1'b0;
                apbPenable <= 1'b0;
                apbPwrite  <= 1'b0;
              end
            end
          end
        end
        SYNC: begin
          if (holdCnt == HOLD_LAST) begin
            state     <= IDLE;
            syncStart <= 1'b0;
            frameDone <= 1'b0;
          end else begin
            holdCnt   <= holdCnt + 8'd1;
            frameDone <= ((holdCnt + 8'd1) == HOLD_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/anton_neopixel_apb_loader.md
# anton_neopixel_apb_loader

Streaming APB master that feeds the neopixel APB slave from upstream. It accepts pixel bytes on a valid/ready stream and buffers them in a small FIFO. Each byte is issued as an APB write into the raw pixel buffer at an auto-incrementing index, and `syncStart` is raised after the last byte of each frame. It sits between a pixel source (DMA, pattern generator, soft core) and the neopixel APB slave, sharing that slave's APB clock.

## Interface

Parameters:
- BUFFER_END, `BUFFER_END_DEFAULT` (anton_common.vh): last valid byte index; the index wraps to 0 after it.
- FIFO_DEPTH, 4: stream FIFO entries (power of two, ≥2).
- REGION, 2'b00: value driven on apbPaddr[19:18] (raw region).
- SYNC_HOLD, 4: cycles syncStart stays high; must cover ≥1 full clk6_4mhz period.

Ports:
- apbPclk  in  1  sole clock.
- apbPresern  in  1  reset; synchronous, active-low.
- pixValid  in  1  stream byte valid.
- pixData  in  8  pixel byte.
- pixLast  in  1  marks final byte of a frame.
- pixReady  out  1  FIFO can accept.
- apbPselx  out  1  APB select.
- apbPenable  out  1  APB enable.
- apbPwrite  out  1  always 1 while apbPselx is high, else 0.
- apbPaddr  out  20  {REGION, index[15:0], 2'b00}.
- apbPwData  out  8  write byte.
- apbPready  in  1  slave ready.
- apbPslverr  in  1  slave error.
- syncStart  out  1  frame-commit pulse to the slave.
- frameDone  out  1  one-cycle pulse on the last SYNC cycle.
- slvErr  out  1  sticky; set on any errored transfer.
- busy  out  1  state≠IDLE or FIFO non-empty.

## Operation

- **Reset values.** While apbPresern=0 at an edge, all registered outputs are 0: apbPselx, apbPenable, apbPwrite, apbPaddr, apbPwData, syncStart, frameDone, slvErr. The FIFO empties, index=0, state=IDLE. pixReady is forced 0 while apbPresern is low.
- **FIFO.**
  - Stores {pixLast, pixData}.
  - pixReady = !full, with no push-through-pop when full.
  - A push occurs on pixValid&&pixReady.
  - A simultaneous push and pop is legal whenever the FIFO is not full.
- **FSM states: IDLE, SETUP, ACCESS, SYNC.**
  - IDLE: when the FIFO is non-empty, go to SETUP.
  - SETUP: apbPselx=1, apbPenable=0, apbPwrite=1. apbPaddr is formed from the index; apbPwData comes from the FIFO head. Go to ACCESS unconditionally.
  - ACCESS: apbPenable=1. apbPaddr and apbPwData are held stable. On an edge with apbPready=1:
    - Pop the FIFO.
    - If apbPslverr=1, set slvErr. The byte is still consumed, with no retry.
    - If head.last=1: index←0, go to SYNC.
    - Otherwise: index←(index==BUFFER_END)?0:index+1. Go to SETUP if the FIFO still holds an entry after the pop, else IDLE.
  - SYNC: syncStart=1 and apbPselx=0 for SYNC_HOLD cycles. frameDone=1 on the final one. Then go to IDLE. The FIFO keeps accepting during SYNC.
- **Index arithmetic.**
  - The index is 16 bits; index==BUFFER_END is compared before incrementing.
  - Wrap is silent: a frame longer than BUFFER_END+1 overwrites from index 0.
- After a wrap and at frame end, the next write always targets index 0.
- apbPselx/apbPenable deassert only from IDLE or SYNC. There is no idle cycle between back-to-back transfers other than the SETUP phase.

## Timing

- Byte accepted at edge N → state SETUP after edge N+1 (apbPselx high in cycle N+1..N+2).
- Zero-wait slave: 2 cycles per byte, giving sustained throughput of 1 byte per 2 cycles.
- Each low apbPready in ACCESS adds 1 cycle; outputs hold unchanged.
- Last-byte completion at edge M → syncStart high for cycles M..M+SYNC_HOLD-1, and frameDone high in cycle M+SYNC_HOLD-1. The earliest next SETUP is after edge M+SYNC_HOLD+1.
- Reset asserted mid-ACCESS → apbPselx/apbPenable low after the same edge. The transfer is abandoned and FIFO contents are discarded.

## Test plan

- **Reset.** Hold apbPresern=0 for 3 cycles with pixValid=1 → every output is 0 and pixReady=0. On release, pixReady=1 and busy=0.
- **Single frame.** Zero-wait slave, bytes 0x11,0x22,0x33 with pixLast on 0x33.
  - Writes go to apbPaddr 0x00000, 0x00004, 0x00008 with matching apbPwData, 2 cycles each.
  - syncStart is high for 4 cycles after the third completion, with frameDone on the 4th.
  - The next frame's first write goes to 0x00000.
- **Wait states.** Slave holds apbPready=0 for 3 cycles on the first write while the source pushes 6 bytes.
  - Address and data stay stable and no pop occurs.
  - pixReady drops once 4 entries are buffered.
  - All 6 bytes arrive in order.
- **Wrap.** With BUFFER_END=3, stream 6 bytes with no pixLast → addresses 0x0,0x4,0x8,0xC,0x0,0x4, and syncStart never asserts.
- **Slave error.** Assert apbPslverr on the 2nd of 4 transfers → slvErr=1 from that edge and stays 1. All 4 bytes are consumed and indices advance 0..3.
- **Reset mid-transfer.** Assert reset during ACCESS of index 5 → apbPselx=0 next edge and the FIFO is empty. After release, the first new byte is written to index 0.
